// File: rtl/mpc_mac_pipe.sv
// Pipelined signed multiply-accumulate with a valid tag, optional running sum,
// round-half-up scaling and saturation to the output width.
module mpc_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 4,
  parameter int DIN0_WIDTH = 21,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 29,
  parameter int ACC_WIDTH  = 40,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         din_vld,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         acc_en,
  input  logic                         first,
  output logic                         dout_vld,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat
);

  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int TD  = NUM_STAGE - 1;
  localparam int MD  = NUM_STAGE - 2;
  localparam int MDA = (MD > 0) ? MD : 1;
  localparam int XW  = ACC_WIDTH + 1;

  localparam logic signed [XW-1:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0] OUT_MAX = {{(XW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] OUT_MIN = {{(XW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0] RND     = (XW'(1) << SHIFT) >> 1;

  // ID only labels the instance; referenced here so it stays visible in the hierarchy.
  if (ID < 0) begin : g_id_tag
  end

  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH-1:0] b_q;
  logic                         vld_q   [TD];
  logic                         acc_en_q[TD];
  logic                         first_q [TD];
  logic signed [PW-1:0]         prod_q  [MDA];
  logic signed [ACC_WIDTH-1:0]  acc_q;

  logic signed [PW-1:0] mult_w;
  logic signed [PW-1:0] prod_w;
  assign mult_w = PW'(a_q) * PW'(b_q);

  if (MD == 0) begin : g_comb_mult
    assign prod_w = mult_w;
  end else begin : g_pipe_mult
    assign prod_w = prod_q[MDA-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < TD; i++) begin
        vld_q[i]    <= 1'b0;
        acc_en_q[i] <= 1'b0;
        first_q[i]  <= 1'b0;
      end
      for (int i = 0; i < MDA; i++) prod_q[i] <= '0;
    end else if (ce) begin
      a_q         <= din0;
      b_q         <= din1;
      vld_q[0]    <= din_vld;
      acc_en_q[0] <= acc_en;
      first_q[0]  <= first;
      for (int i = 1; i < TD; i++) begin
        vld_q[i]    <= vld_q[i-1];
        acc_en_q[i] <= acc_en_q[i-1];
        first_q[i]  <= first_q[i-1];
      end
      prod_q[0] <= mult_w;
      for (int i = 1; i < MDA; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  logic                 vld_t, acc_en_t, first_t;
  logic signed [XW-1:0] sum_w, s_w, rnd_w, r_w;
  logic                 add_ovf_w, ovf_w, clamp_w;
  logic signed [DOUT_WIDTH-1:0] dout_d;

  assign vld_t     = vld_q[TD-1];
  assign acc_en_t  = acc_en_q[TD-1];
  assign first_t   = first_q[TD-1];
  assign sum_w     = XW'(acc_q) + XW'(prod_w);
  assign add_ovf_w = sum_w[XW-1] != sum_w[XW-2];

  // The extra top bit keeps the add and the rounding offset overflow-free.
  always_comb begin
    s_w   = XW'(prod_w);
    ovf_w = 1'b0;
    if (acc_en_t && !first_t) begin
      ovf_w = add_ovf_w;
      if (add_ovf_w) s_w = sum_w[XW-1] ? ACC_MIN : ACC_MAX;
      else           s_w = sum_w;
    end
    rnd_w   = s_w + RND;
    r_w     = rnd_w >>> SHIFT;
    clamp_w = 1'b0;
    dout_d  = r_w[DOUT_WIDTH-1:0];
    if (r_w > OUT_MAX) begin
      clamp_w = 1'b1;
      dout_d  = OUT_MAX[DOUT_WIDTH-1:0];
    end else if (r_w < OUT_MIN) begin
      clamp_w = 1'b1;
      dout_d  = OUT_MIN[DOUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_vld <= 1'b0;
      dout     <= '0;
      sat      <= 1'b0;
      acc_q    <= '0;
    end else if (ce) begin
      dout_vld <= vld_t;
      if (vld_t) begin
        dout <= dout_d;
        sat  <= ovf_w | clamp_w;
        if (acc_en_t) acc_q <= s_w[ACC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mpc_mac_pipe.sv
// Directed bench for mpc_mac_pipe: stimulus pushes hand-computed results into
// per-instance queues; a negedge monitor pops and compares each dout_vld.
module tb_mpc_mac_pipe;

  logic clk = 1'b0;
  logic reset, ce;
  logic din_vld_a, acc_en_a, first_a;
  logic signed [20:0] din0_a;
  logic signed [7:0]  din1_a;
  logic dout_vld_a, sat_a;
  logic signed [28:0] dout_a;
  logic din_vld_b, acc_en_b, first_b;
  logic signed [20:0] din0_b;
  logic signed [7:0]  din1_b;
  logic dout_vld_b, sat_b;
  logic signed [28:0] dout_b;

  always #5 clk = ~clk;

  mpc_mac_pipe u_dut_a (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld_a),
    .din0(din0_a), .din1(din1_a), .acc_en(acc_en_a), .first(first_a),
    .dout_vld(dout_vld_a), .dout(dout_a), .sat(sat_a)
  );

  mpc_mac_pipe #(.SHIFT(4)) u_dut_b (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld_b),
    .din0(din0_b), .din1(din1_b), .acc_en(acc_en_b), .first(first_b),
    .dout_vld(dout_vld_b), .dout(dout_b), .sat(sat_b)
  );

  typedef struct {
    logic signed [28:0] d;
    logic               s;
    int                 due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  logic ce_seen = 1'b0;

  // Count only edges on which the DUT actually advances.
  always @(posedge clk) begin
    ce_seen <= ce && reset;
    if (ce && reset) edge_cnt <= edge_cnt + 1;
  end

  task automatic mon(input string nm, input bit which, input logic v,
                     input logic signed [28:0] d, input logic s);
    exp_t e;
    int   sz;
    sz = which ? qb.size() : qa.size();
    if (v) begin
      n_vec++;
      if (sz == 0) begin
        n_bad++;
        $display("FAIL %s spurious: dout=%0d sat=%0b edge=%0d, required no output", nm, d, s, edge_cnt);
      end else begin
        e = which ? qb.pop_front() : qa.pop_front();
        if (d !== e.d || s !== e.s || edge_cnt != e.due) begin
          n_bad++;
          $display("FAIL %s: dout=%0d sat=%0b edge=%0d, required dout=%0d sat=%0b edge=%0d",
                   nm, d, s, edge_cnt, e.d, e.s, e.due);
        end else begin
          $display("ok %s: dout=%0d sat=%0b edge=%0d", nm, d, s, edge_cnt);
        end
      end
    end else if (sz > 0) begin
      e = which ? qb[0] : qa[0];
      if (edge_cnt >= e.due) begin
        n_vec++;
        n_bad++;
        if (which) void'(qb.pop_front()); else void'(qa.pop_front());
        $display("FAIL %s missing: no dout_vld by edge %0d, required dout=%0d at edge %0d",
                 nm, edge_cnt, e.d, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset && ce_seen) begin
      mon("dut_a", 1'b0, dout_vld_a, dout_a, sat_a);
      mon("dut_b", 1'b1, dout_vld_b, dout_b, sat_b);
    end
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end else begin
      $display("ok %s: %0d", nm, act);
    end
  endtask

  task automatic drive(input bit to_b, input int a, input int b, input bit ae, input bit fi);
    if (to_b) begin
      din_vld_b = 1'b1; din0_b = 21'(a); din1_b = 8'(b); acc_en_b = ae; first_b = fi;
    end else begin
      din_vld_a = 1'b1; din0_a = 21'(a); din1_a = 8'(b); acc_en_a = ae; first_a = fi;
    end
  endtask

  // Called at posedge+1; gap=1 holds the sample on the inputs for one ce=0 cycle first.
  task automatic issue(input bit gap, input bit to_b, input int a, input int b,
                       input bit ae, input bit fi, input bit keep,
                       input int exp_d, input bit exp_s);
    exp_t e;
    if (gap) begin
      ce = 1'b0;
      drive(to_b, a, b, ae, fi);
      @(posedge clk); #1;
    end
    ce = 1'b1;
    drive(to_b, a, b, ae, fi);
    if (keep) begin
      e.d = 29'(exp_d); e.s = exp_s; e.due = edge_cnt + 4;
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
    @(posedge clk); #1;
    din_vld_a = 1'b0;
    din_vld_b = 1'b0;
  endtask

  task automatic idle(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) ce = ~ce;
      @(posedge clk); #1;
    end
    ce = 1'b1;
  endtask

  initial begin
    reset = 1'b0; ce = 1'b0;
    din_vld_a = 1'b0; din0_a = '0; din1_a = '0; acc_en_a = 1'b0; first_a = 1'b0;
    din_vld_b = 1'b0; din0_b = '0; din1_b = '0; acc_en_b = 1'b0; first_b = 1'b0;
    #1;
    chk("reset dout_vld", longint'(dout_vld_a), 0);
    chk("reset dout", longint'(dout_a), 0);
    chk("reset sat", longint'(sat_a), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; ce = 1'b1;

    // Single full-scale product, default instance.
    issue(0, 0, -1048576, -128, 0, 0, 1, 134217728, 0);
    idle(6, 0);

    // Back-to-back samples with ce alternating.
    for (int i = 0; i < 8; i++) issue(1, 0, i, 3, 0, 0, 1, 3 * i, 0);
    idle(12, 1);

    // Running accumulation with a restart on the fifth sample.
    for (int i = 0; i < 4; i++) issue(0, 0, 1000, 100, 1, i == 0, 1, 100000 * (i + 1), 0);
    issue(0, 0, 1000, 100, 1, 1, 1, 100000, 0);
    idle(6, 0);

    // Accumulation growing past the output range.
    issue(0, 0, 1048575, 127, 1, 1, 1, 133169025, 0);
    issue(0, 0, 1048575, 127, 1, 0, 1, 266338050, 0);
    issue(0, 0, 1048575, 127, 1, 0, 1, 268435455, 1);
    idle(6, 0);

    // Round-half-up with SHIFT=4.
    issue(0, 1, 24, 1, 0, 0, 1, 2, 0);
    issue(0, 1, -24, 1, 0, 0, 1, -1, 0);
    issue(0, 1, 8, 1, 0, 0, 1, 1, 0);
    issue(0, 1, 7, 1, 0, 0, 1, 0, 0);
    idle(6, 0);

    // Reset with two samples in flight behind a completed one.
    issue(0, 0, 5, 7, 0, 0, 1, 35, 0);
    issue(0, 0, 6, 7, 0, 0, 0, 0, 0);
    issue(0, 0, 9, 7, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async reset dout_vld", longint'(dout_vld_a), 0);
    chk("async reset dout", longint'(dout_a), 0);
    chk("async reset sat", longint'(sat_a), 0);
    qa.delete();
    @(posedge clk); #1 reset = 1'b1;
    idle(6, 0);
    issue(0, 0, -3, 9, 1, 0, 1, -27, 0);
    idle(6, 0);

    chk("queue a drained", longint'(qa.size()), 0);
    chk("queue b drained", longint'(qb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
